// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stage indices, stall/flush patterns and FSM states for pipe_ctrl
package pipe_ctrl_pkg;

    localparam int STG_PC      = 0;
    localparam int STG_IF_ID   = 1;
    localparam int STG_ID_EXE  = 2;
    localparam int STG_EXE_MEM = 3;
    localparam int STG_MEM_WB  = 4;
    localparam int STG_WB      = 5;
    localparam int NUM_STAGES  = STG_WB + 1;

    // Stall patterns are always a contiguous run from the PC up to a given stage
    function automatic logic [NUM_STAGES-1:0] stall_upto(input int last);
        logic [NUM_STAGES-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (i <= last) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [NUM_STAGES-1:0] STALL_NONE    = '0;
    localparam logic [NUM_STAGES-1:0] STALL_LOADUSE = stall_upto(STG_ID_EXE);
    localparam logic [NUM_STAGES-1:0] STALL_MC      = stall_upto(STG_EXE_MEM);
    localparam logic [NUM_STAGES-1:0] STALL_MEM     = stall_upto(STG_MEM_WB);

    localparam logic [NUM_STAGES-1:0] FLUSH_NONE = '0;
    // A taken jump kills the two younger instructions sitting in IF/ID and ID/EXE
    localparam logic [NUM_STAGES-1:0] FLUSH_JUMP =
        NUM_STAGES'((1 << STG_IF_ID) | (1 << STG_ID_EXE));

    typedef enum logic {
        S_RUN     = 1'b0,
        S_MC_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_ctrl_load_use_det.sv
// rtl/pipe_ctrl_load_use_det.sv - load-use hazard detect between EXE load and ID operands
module pipe_ctrl_load_use_det (
    input  logic       id_reg1_re_i,
    input  logic       id_reg2_re_i,
    input  logic [4:0] id_reg1_raddr_i,
    input  logic [4:0] id_reg2_raddr_i,
    input  logic       exe_is_load_i,
    input  logic       exe_reg_we_i,
    input  logic [4:0] exe_reg_waddr_i,
    output logic       load_use_o
);

    // x0 is never a real dependency, so a load targeting it cannot cause a hazard
    always_comb begin
        load_use_o = 1'b0;
        if (exe_is_load_i && exe_reg_we_i && (exe_reg_waddr_i != 5'd0)) begin
            load_use_o = (id_reg1_re_i && (id_reg1_raddr_i == exe_reg_waddr_i)) ||
                         (id_reg2_re_i && (id_reg2_raddr_i == exe_reg_waddr_i));
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/redirect sequencing controller
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_reg1_re_i,
    input  logic             id_reg2_re_i,
    input  logic [4:0]       id_reg1_raddr_i,
    input  logic [4:0]       id_reg2_raddr_i,
    input  logic             exe_is_load_i,
    input  logic             exe_reg_we_i,
    input  logic [4:0]       exe_reg_waddr_i,
    input  logic             exe_mc_start_i,
    input  logic             exe_mc_done_i,
    input  logic             mem_req_i,
    input  logic             mem_gnt_i,
    input  logic             exe_jump_i,
    input  logic [31:0]      exe_jump_addr_i,
    output logic [5:0]       stall_o,
    output logic [5:0]       flush_o,
    output logic             redirect_o,
    output logic [31:0]      redirect_addr_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             err_o
);

    localparam int TO_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             jump_pend_q, jump_pend_d;
    logic [31:0]      jump_addr_q, jump_addr_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             err_q, err_d;

    logic        load_use;
    logic        mem_wait, to_hit, mc_wait, blocked, jump_go;
    logic [5:0]  stall, flush;
    logic        redirect;
    logic [31:0] redirect_addr;

    pipe_ctrl_load_use_det u_load_use_det (
        .id_reg1_re_i    (id_reg1_re_i),
        .id_reg2_re_i    (id_reg2_re_i),
        .id_reg1_raddr_i (id_reg1_raddr_i),
        .id_reg2_raddr_i (id_reg2_raddr_i),
        .exe_is_load_i   (exe_is_load_i),
        .exe_reg_we_i    (exe_reg_we_i),
        .exe_reg_waddr_i (exe_reg_waddr_i),
        .load_use_o      (load_use)
    );

    // Stall causes; the watchdog cycle releases the stall just like a done cycle
    always_comb begin
        mem_wait = mem_req_i && !mem_gnt_i;
        to_hit   = (state_q == S_MC_WAIT) && (to_cnt_q == TO_LAST);
        mc_wait  = ((state_q == S_RUN) && exe_mc_start_i) ||
                   ((state_q == S_MC_WAIT) && !exe_mc_done_i && !to_hit);
        blocked  = mem_wait || mc_wait;
        jump_go  = !blocked && (jump_pend_q || exe_jump_i);
    end

    // Priority resolve into stall/flush/redirect; everything forced quiet in reset
    always_comb begin
        stall         = STALL_NONE;
        flush         = FLUSH_NONE;
        redirect      = 1'b0;
        redirect_addr = '0;
        if (rst_i) begin
            if (mem_wait) begin
                stall = STALL_MEM;
            end else if (mc_wait) begin
                stall = STALL_MC;
            end else if (jump_go) begin
                flush         = FLUSH_JUMP;
                redirect      = 1'b1;
                redirect_addr = jump_pend_q ? jump_addr_q : exe_jump_addr_i;
            end else if (load_use) begin
                stall = STALL_LOADUSE;
            end
        end
    end

    // Multi-cycle wait FSM with watchdog
    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
        case (state_q)
            S_RUN: begin
                if (exe_mc_start_i) begin
                    state_d  = S_MC_WAIT;
                    to_cnt_d = '0;
                end
            end
            S_MC_WAIT: begin
                if (exe_mc_done_i) begin
                    state_d = S_RUN;
                end else if (to_hit) begin
                    state_d = S_RUN;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // Hold the oldest jump that arrived while stalled until the stall clears
    always_comb begin
        jump_pend_d = jump_pend_q;
        jump_addr_d = jump_addr_q;
        if (blocked) begin
            if (exe_jump_i && !jump_pend_q) begin
                jump_pend_d = 1'b1;
                jump_addr_d = exe_jump_addr_i;
            end
        end else begin
            jump_pend_d = 1'b0;
        end
    end

    // Saturating count of cycles where the PC is held
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall[STG_PC] && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_RUN;
            jump_pend_q <= 1'b0;
            jump_addr_q <= '0;
            to_cnt_q    <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            jump_pend_q <= jump_pend_d;
            jump_addr_q <= jump_addr_d;
            to_cnt_q    <= to_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign stall_o         = stall;
    assign flush_o         = flush;
    assign redirect_o      = redirect;
    assign redirect_addr_o = redirect_addr;
    assign stall_cnt_o     = stall_cnt_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    localparam int MC_TIMEOUT = 8;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic        clk, rst_n;
    logic        re1, re2, is_load, we, start, done, mem_req, mem_gnt, jump;
    logic [4:0]  ra1, ra2, waddr;
    logic [31:0] jaddr;
    logic [5:0]  stall_o, flush_o;
    logic        redirect_o, err_o;
    logic [31:0] redirect_addr_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic        m_busy, m_pend, m_err;
    int          m_age, m_cnt;
    logic [31:0] m_paddr;
    logic        e_stall0, e_blocked;
    logic [49:0] exp_vec;
    wire  [49:0] obs_vec = {stall_o, flush_o, redirect_o, redirect_addr_o, stall_cnt_o, err_o};

    pipe_ctrl #(.MC_TIMEOUT(MC_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .id_reg1_re_i    (re1),
        .id_reg2_re_i    (re2),
        .id_reg1_raddr_i (ra1),
        .id_reg2_raddr_i (ra2),
        .exe_is_load_i   (is_load),
        .exe_reg_we_i    (we),
        .exe_reg_waddr_i (waddr),
        .exe_mc_start_i  (start),
        .exe_mc_done_i   (done),
        .mem_req_i       (mem_req),
        .mem_gnt_i       (mem_gnt),
        .exe_jump_i      (jump),
        .exe_jump_addr_i (jaddr),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .redirect_o      (redirect_o),
        .redirect_addr_o (redirect_addr_o),
        .stall_cnt_o     (stall_cnt_o),
        .err_o           (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        re1 = 0; re2 = 0; ra1 = 0; ra2 = 0; is_load = 0; we = 0; waddr = 0;
        start = 0; done = 0; mem_req = 0; mem_gnt = 0; jump = 0; jaddr = 0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_pend = 0; m_err = 0; m_age = 0; m_cnt = 0; m_paddr = 0;
    endtask

    // Expected outputs from the rules: priority mem > mc > jump > load-use
    task automatic eval_model();
        logic mw, mc, lu, go;
        logic [5:0] st, fl;
        logic [31:0] ad;
        mw = mem_req && !mem_gnt;
        if (!m_busy) mc = start;
        else         mc = !done && (m_age < MC_TIMEOUT);
        lu = is_load && we && (waddr != 0) &&
             ((re1 && ra1 == waddr) || (re2 && ra2 == waddr));
        go = !(mw || mc) && (m_pend || jump);
        ad = go ? (m_pend ? m_paddr : jaddr) : 32'd0;
        st = mw ? 6'h1f : mc ? 6'h0f : go ? 6'h00 : lu ? 6'h07 : 6'h00;
        fl = go ? 6'h06 : 6'h00;
        exp_vec   = {st, fl, go, ad, 4'(m_cnt), m_err};
        e_stall0  = st[0];
        e_blocked = mw || mc;
    endtask

    // Advance model by one clock, then move to just after the edge
    task automatic advance();
        if (e_stall0 && m_cnt < CNT_MAX) m_cnt++;
        if (!m_busy) begin
            if (start) begin m_busy = 1; m_age = 1; end
        end else if (done) begin
            m_busy = 0;
        end else if (m_age == MC_TIMEOUT) begin
            m_busy = 0; m_err = 1;
        end else begin
            m_age++;
        end
        if (e_blocked) begin
            if (jump && !m_pend) begin m_pend = 1; m_paddr = jaddr; end
        end else begin
            m_pend = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        jump = 1; jaddr = 32'hdead_beef; mem_req = 1; start = 1;
        rst_n = 0;
        #2;
        n_vec++;
        if (obs_vec !== 50'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h need 0", obs_vec);
        end
        apply_reset();
        @(negedge clk); eval_model();
        n_vec++;
        if (obs_vec !== exp_vec) begin
            n_err++; $display("FAIL reset_idle: got %h need %h", obs_vec, exp_vec);
        end
        advance();
    endtask

    task automatic test_load_use();
        apply_reset();
        is_load = 1; we = 1; waddr = 5; re2 = 1; ra2 = 5; re1 = 1; ra1 = 7;
        @(negedge clk); eval_model();
        n_vec++;
        if (stall_o !== 6'b000111) begin
            n_err++; $display("FAIL lu_stall: got %b need 000111", stall_o);
        end
        n_vec++;
        if (obs_vec !== exp_vec) begin
            n_err++; $display("FAIL lu_model: got %h need %h", obs_vec, exp_vec);
        end
        advance();
        waddr = 0; ra2 = 0;
        @(negedge clk); eval_model();
        n_vec++;
        if (stall_o !== 6'b000000) begin
            n_err++; $display("FAIL lu_x0: got %b need 000000", stall_o);
        end
        advance();
    endtask

    task automatic test_mc();
        apply_reset();
        for (int i = 0; i <= 5; i++) begin
            idle_inputs();
            start = (i == 0);
            done  = (i == 5);
            @(negedge clk); eval_model();
            n_vec++;
            if (stall_o !== ((i < 5) ? 6'b001111 : 6'b000000)) begin
                n_err++; $display("FAIL mc_stall[%0d]: got %b", i, stall_o);
            end
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++; $display("FAIL mc_model[%0d]: got %h need %h", i, obs_vec, exp_vec);
            end
            advance();
        end
        idle_inputs();
        n_vec++;
        if (stall_cnt_o !== 4'd5) begin
            n_err++; $display("FAIL mc_count: got %0d need 5", stall_cnt_o);
        end
    endtask

    task automatic test_mem_jump();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            mem_req = (i < 3);
            jump    = (i == 0);
            jaddr   = (i == 0) ? 32'h100 : 32'h0;
            @(negedge clk); eval_model();
            n_vec++;
            if (i < 3 && stall_o !== 6'b011111) begin
                n_err++; $display("FAIL memj_stall[%0d]: got %b need 011111", i, stall_o);
            end
            if (i == 3 && {redirect_o, redirect_addr_o, flush_o} !== {1'b1, 32'h100, 6'b000110}) begin
                n_err++;
                $display("FAIL memj_redirect: got %b %h %b need 1 100 000110",
                         redirect_o, redirect_addr_o, flush_o);
            end
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++; $display("FAIL memj_model[%0d]: got %h need %h", i, obs_vec, exp_vec);
            end
            advance();
        end
        idle_inputs();
        @(negedge clk); eval_model();
        n_vec++;
        if (redirect_o !== 1'b0) begin
            n_err++; $display("FAIL memj_pend_clear: got %b need 0", redirect_o);
        end
        advance();
    endtask

    task automatic test_jump_lu();
        apply_reset();
        is_load = 1; we = 1; waddr = 9; re1 = 1; ra1 = 9;
        jump = 1; jaddr = 32'h40;
        @(negedge clk); eval_model();
        n_vec++;
        if ({flush_o, stall_o, redirect_addr_o} !== {6'b000110, 6'b000000, 32'h40}) begin
            n_err++;
            $display("FAIL jump_lu: got %b %b %h need 000110 000000 40", flush_o, stall_o, redirect_addr_o);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int i = 0; i <= MC_TIMEOUT; i++) begin
            idle_inputs();
            start = (i == 0);
            @(negedge clk); eval_model();
            n_vec++;
            if (stall_o !== ((i < MC_TIMEOUT) ? 6'b001111 : 6'b000000)) begin
                n_err++; $display("FAIL to_stall[%0d]: got %b", i, stall_o);
            end
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++; $display("FAIL to_model[%0d]: got %h need %h", i, obs_vec, exp_vec);
            end
            advance();
        end
        idle_inputs();
        start = 1;
        @(negedge clk); eval_model();
        n_vec++;
        if ({err_o, stall_o} !== {1'b1, 6'b001111}) begin
            n_err++; $display("FAIL to_after: got err=%b stall=%b need 1 001111", err_o, stall_o);
        end
        advance();
        idle_inputs(); done = 1;
        @(negedge clk); eval_model(); advance();
        idle_inputs();
    endtask

    task automatic test_async_reset();
        apply_reset();
        start = 1;
        @(negedge clk); eval_model(); advance();
        idle_inputs(); mem_req = 1; jump = 1; jaddr = 32'h200;
        @(negedge clk); eval_model(); advance();
        idle_inputs(); jump = 1; jaddr = 32'h300;
        #2;
        rst_n = 0;
        #1;
        n_vec++;
        if (obs_vec !== 50'd0) begin
            n_err++; $display("FAIL async_rst: got %h need 0", obs_vec);
        end
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        @(negedge clk); eval_model();
        n_vec++;
        if (redirect_o !== 1'b0) begin
            n_err++; $display("FAIL async_no_redirect: got %b need 0", redirect_o);
        end
        n_vec++;
        if (obs_vec !== exp_vec) begin
            n_err++; $display("FAIL async_model: got %h need %h", obs_vec, exp_vec);
        end
        advance();
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 500; i++) begin
            re1     = $urandom_range(0, 1);
            re2     = $urandom_range(0, 1);
            ra1     = 5'($urandom_range(0, 3));
            ra2     = 5'($urandom_range(0, 3));
            waddr   = 5'($urandom_range(0, 3));
            is_load = $urandom_range(0, 1);
            we      = ($urandom_range(0, 3) != 0);
            start   = ($urandom_range(0, 7) == 0);
            done    = ($urandom_range(0, 3) == 0);
            mem_req = ($urandom_range(0, 2) == 0);
            mem_gnt = $urandom_range(0, 1);
            jump    = ($urandom_range(0, 3) == 0);
            jaddr   = $urandom;
            @(negedge clk); eval_model();
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++; $display("FAIL rand[%0d]: got %h need %h", i, obs_vec, exp_vec);
            end
            advance();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 1;
        #1;
        test_reset();
        test_load_use();
        test_mc();
        test_mem_jump();
        test_jump_lu();
        test_timeout();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencing controller for the 5-stage RV32I core. It gathers stall causes that operand forwarding cannot resolve: load-use, multi-cycle EXE ops, data-bus wait and pending jumps. It drives per-stage stall and flush vectors to every pipeline register, plus the PC redirect. It sits beside the stage modules; the ID-stage forwarding muxes stay in ID.

## Interface
Parameters:
- MC_TIMEOUT, 64, maximum cycles in multi-cycle wait before the watchdog fires.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset. Asynchronous, active-low.
- id_reg1_re_i / id_reg2_re_i  in  1  ID operand read enables.
- id_reg1_raddr_i / id_reg2_raddr_i  in  5  ID source register addresses.
- exe_is_load_i  in  1  instruction in EXE is a load.
- exe_reg_we_i  in  1  EXE write enable.
- exe_reg_waddr_i  in  5  EXE destination register.
- exe_mc_start_i  in  1  multi-cycle op (div/mul) issued this cycle.
- exe_mc_done_i  in  1  multi-cycle result valid.
- mem_req_i / mem_gnt_i  in  1  data-bus request and grant.
- exe_jump_i  in  1  taken branch or jump resolved in EXE.
- exe_jump_addr_i  in  32  jump target.
- stall_o  out  6  bit k holds stage k: 0 pc, 1 if_id, 2 id_exe, 3 exe_mem, 4 mem_wb, 5 wb.
- flush_o  out  6  bit k clears pipeline register k to NOP.
- redirect_o  out  1  load PC from redirect_addr_o.
- redirect_addr_o  out  32  redirect target.
- stall_cnt_o  out  CNT_W  cycles with stall_o[0]=1, saturating.
- err_o  out  1  sticky multi-cycle watchdog error.

## Operation
- Stall patterns are always a contiguous run [k:0]. Pipeline registers insert a bubble where stall[k]=1 and stall[k+1]=0.
- Causes, in priority order:
  - mem_wait = mem_req_i & ~mem_gnt_i → stall 6'b011111.
  - mc = exe_mc_start_i in S_RUN, or state S_MC_WAIT with ~exe_mc_done_i → stall 6'b001111.
  - Jump (live or pending) → flush 6'b000110, redirect_o=1.
  - Load-use → stall 6'b000111. Load-use is exe_is_load_i & exe_reg_we_i & exe_reg_waddr_i≠0 & ((id_reg1_re_i & raddr1==waddr) | (id_reg2_re_i & raddr2==waddr)).
- Jump and load-use in the same cycle: jump wins and load-use is suppressed, because the ID instruction is flushed.
- A jump arriving while mem_wait or mc is active is latched into jump_pend with its address in jump_addr_q. A newer jump never overwrites a pending one. The pending jump is issued on the first cycle with no mem_wait/mc, with redirect_addr_o = jump_addr_q; jump_pend then clears.
- FSM states:
  - S_RUN: exe_mc_start_i → S_MC_WAIT.
  - S_MC_WAIT: exe_mc_done_i → S_RUN, and stall releases in the done cycle. Timeout counter reaching MC_TIMEOUT-1 without done → err_o set, then S_RUN.
  - The timeout counter clears on entry and counts every cycle in S_MC_WAIT, including mem_wait cycles.
- exe_mc_start_i outside S_RUN is ignored.
- When no cause is active, stall_o, flush_o and redirect_o are 0.
- stall_cnt_o increments whenever stall_o[0]=1 and saturates at all-ones.
- err_o clears only on reset.

## Timing
- stall_o, flush_o, redirect_o and redirect_addr_o are combinational from the inputs and the registered state: zero latency.
- State, jump_pend, jump_addr_q, the timeout counter, stall_cnt_o and err_o are registered.
- Reset, asynchronous at any time including mid-wait: state=S_RUN, jump_pend=0, counters=0, err_o=0. While reset is asserted, all outputs are 0 and redirect_addr_o=0.
- A multi-cycle op started at cycle t with done at t+n stalls cycles t..t+n-1, i.e. n cycles.

## Structure
- Shared defines, placed with the existing core defines: stage index constants, stall pattern constants (STALL_NONE, STALL_LOADUSE, STALL_MC, STALL_MEM), FLUSH_JUMP, FSM state encodings.
- One sub-module, load_use_det: the combinational register-address compare producing the load-use flag.

## Test plan
- Load x5 in EXE, ID reads x5 via rs2 → stall_o=6'b000111 for 1 cycle. Same with waddr=x0 → stall_o=0.
- mc_start at t, done at t+5 → stall_o=6'b001111 for cycles t..t+4; stall_cnt_o=5.
- mem_req=1, gnt=0 for 3 cycles, with exe_jump_i=1 and target 0x100 in the first of them → stall 6'b011111 for 3 cycles; next cycle redirect_o=1, addr=0x100, flush_o=6'b000110.
- Jump to 0x40 coincident with load-use → flush_o=6'b000110, stall_o=0, redirect_addr_o=0x40.
- MC_TIMEOUT=4, mc_start with no done → stall for 4 cycles, err_o=1 thereafter, state back to S_RUN.
- rst_i low during S_MC_WAIT with a jump pending → all outputs 0 immediately; after release no redirect occurs.
